aes_key_sched_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_key_round.sv | 43 ++++
 rtl/aes_key_sched_ctrl.sv | 149 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the key-schedule slice.
//   AES_NR / AES_KW : round count and key width for AES-128.
//   state_t         : controller states (IDLE, EXPAND).
//   RCON            : round constants for rounds 0..9 (MSB byte of the word).
//   sbox()          : forward AES S-box lookup, one byte in, one byte out.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// -----------------------------------------------------------------------------
// aes_key_round
// One AES-128 key-expansion step, purely combinational.
//   key_in   [127:0] : previous round key, w0 = [127:96] .. w3 = [31:0]
//   rcon_idx [3:0]   : round-constant index 0..9 (other values use rcon 0x00)
//   key_out  [127:0] : next round key
// -----------------------------------------------------------------------------
import aes_pkg::*;

module aes_key_round (
    input  logic [AES_KW-1:0] key_in,
    input  logic [3:0]        rcon_idx,
    output logic [AES_KW-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rc;

    always_comb begin
        w0 = key_in[127:96];
        w1 = key_in[95:64];
        w2 = key_in[63:32];
        w3 = key_in[31:0];

        // Out-of-range indices never occur from the controller; guard anyway.
        rc = (rcon_idx <= 4'd9) ? RCON[rcon_idx] : 8'h00;

        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t   = sub ^ {rc, 24'h000000};

        // Each output word chains off the one just produced.
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;

        key_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// AES-128 round-key expansion sequencer with an 11-entry round-key store.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : expand key_in; taken only in IDLE
//   key_in  [127:0]  : cipher key, sampled on the accepting edge
//   busy             : high while expanding
//   done             : one-cycle pulse after rk10 is written
//   keys_valid       : rk0..rk10 all belong to the last accepted key
//   rk_idx  [3:0]    : read index 0..10
//   rk_out  [127:0]  : registered rk[rk_idx] (zero for rk_idx > 10)
//
// Handshake: start is a single-cycle request with no ready back-pressure.
// It is taken on any rising edge where the controller is in IDLE (including
// the cycle done is high); while busy it is silently dropped and the running
// expansion is unaffected. Completion is signalled only by the done pulse.
// -----------------------------------------------------------------------------
import aes_pkg::*;

module aes_key_sched_ctrl #(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic [3:0]    rk_idx,
    output logic [KW-1:0] rk_out
);

    localparam logic [3:0] LAST_ROUND = 4'(NR - 1);
    localparam logic [3:0] MAX_IDX    = 4'(NR);

    state_t        state, state_nxt;
    logic [3:0]    round, round_nxt;
    logic          done_nxt, kv_nxt;

    logic [KW-1:0] rk [0:NR];
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [KW-1:0] wr_data;

    logic [KW-1:0] cur_key;
    logic [KW-1:0] round_key;

    // Single expansion step shared by all rounds.
    aes_key_round u_key_round (
        .key_in   (cur_key),
        .rcon_idx (round),
        .key_out  (round_key)
    );

    always_comb begin
        cur_key = '0;
        if (round <= LAST_ROUND) begin
            cur_key = rk[round];
        end
    end

    assign busy = (state == EXPAND);

    // Next-state, register-file write and flag logic.
    always_comb begin
        state_nxt = state;
        round_nxt = round;
        done_nxt  = 1'b0;
        kv_nxt    = keys_valid;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;

        case (state)
            IDLE: begin
                round_nxt = '0;
                if (start) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    wr_data   = key_in;
                    kv_nxt    = 1'b0;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (round > LAST_ROUND) begin
                    // Corrupted counter: abandon the run, keys untrusted.
                    state_nxt = IDLE;
                    round_nxt = '0;
                    kv_nxt    = 1'b0;
                end else begin
                    wr_en     = 1'b1;
                    wr_idx    = round + 4'd1;
                    wr_data   = round_key;
                    round_nxt = round + 4'd1;
                    if (round == LAST_ROUND) begin
                        state_nxt = IDLE;
                        round_nxt = '0;
                        done_nxt  = 1'b1;
                        kv_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                round_nxt = '0;
                kv_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            round      <= '0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            round      <= round_nxt;
            done       <= done_nxt;
            keys_valid <= kv_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else if (wr_en) begin
            rk[wr_idx] <= wr_data;
        end
    end

    // Read port: one-cycle latency, out-of-range indices read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_out <= '0;
        end else if (rk_idx <= MAX_IDX) begin
            rk_out <= rk[rk_idx];
        end else begin
            rk_out <= '0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
// Directed bench for the AES-128 key-schedule controller using FIPS-197 and
// all-zero key vectors.
// -----------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY  = 128'h0;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    // ---------------- scoreboard ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [127:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string tag, input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        step();
        start  = 1'b0;
        check_eq({tag, "_busy_after_start"}, 128'(busy), 128'd1);
        check_eq({tag, "_kv_after_start"}, 128'(keys_valid), 128'd0);
    endtask

    // Runs from just after the accepting edge until done is seen (bounded).
    // Optionally pulses start with a zero key at cycles 3 and 7.
    task automatic run_expand(input string tag, input bit noise);
        int n = 0;
        int busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            if (noise && (n == 3 || n == 7)) begin
                start  = 1'b1;
                key_in = ZERO_KEY;
            end else begin
                start  = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 128'(n), 128'd10);
        check_eq({tag, "_busy_cycles"}, 128'(busy_cnt), 128'd10);
        check_eq({tag, "_done"}, 128'(done), 128'd1);
        check_eq({tag, "_keys_valid"}, 128'(keys_valid), 128'd1);
        check_eq({tag, "_busy_low"}, 128'(busy), 128'd0);
    endtask

    task automatic read_check(input string tag, input logic [3:0] idx);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s got=empty_queue exp=entry", tag);
        end else begin
            e      = exp_q.pop_front();
            rk_idx = idx;
            step();
            check_eq(tag, rk_out, e);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int done_seen;

        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_idx = '0;
        step();
        step();
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_eq("rst_kv", 128'(keys_valid), 128'd0);
        check_eq("rst_rk_out", rk_out, 128'd0);
        rst = 1'b0;
        step();

        // FIPS-197 key
        do_start("fips", FIPS_KEY);
        run_expand("fips", 1'b0);
        step();
        check_eq("fips_done_one_cycle", 128'(done), 128'd0);
        check_eq("fips_kv_hold", 128'(keys_valid), 128'd1);
        exp_q.push_back(FIPS_RK1);  read_check("fips_rk1", 4'd1);
        exp_q.push_back(FIPS_RK2);  read_check("fips_rk2", 4'd2);
        exp_q.push_back(FIPS_RK10); read_check("fips_rk10", 4'd10);
        exp_q.push_back(FIPS_KEY);  read_check("fips_rk0", 4'd0);
        exp_q.push_back(128'd0);    read_check("idx11_zero", 4'd11);
        exp_q.push_back(128'd0);    read_check("idx15_zero", 4'd15);

        // All-zero key
        do_start("zero", ZERO_KEY);
        run_expand("zero", 1'b0);
        step();
        exp_q.push_back(ZERO_RK1);  read_check("zero_rk1", 4'd1);
        exp_q.push_back(ZERO_RK2);  read_check("zero_rk2", 4'd2);
        exp_q.push_back(ZERO_RK10); read_check("zero_rk10", 4'd10);

        // start pulses while busy must be ignored
        do_start("noise", FIPS_KEY);
        run_expand("noise", 1'b1);
        step();
        exp_q.push_back(FIPS_RK10); read_check("noise_rk10", 4'd10);
        exp_q.push_back(FIPS_KEY);  read_check("noise_rk0", 4'd0);

        // Reset in the middle of expansion
        do_start("mid", FIPS_KEY);
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 128'(busy), 128'd0);
        check_eq("midrst_done", 128'(done), 128'd0);
        check_eq("midrst_kv", 128'(keys_valid), 128'd0);
        check_eq("midrst_rk_out", rk_out, 128'd0);
        step();
        step();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) done_seen++;
        end
        check_eq("midrst_no_done", 128'(done_seen), 128'd0);
        check_eq("midrst_idle", 128'(busy), 128'd0);
        exp_q.push_back(128'd0);    read_check("midrst_rk1_cleared", 4'd1);
        do_start("restart", FIPS_KEY);
        run_expand("restart", 1'b0);
        step();
        exp_q.push_back(FIPS_RK10); read_check("restart_rk10", 4'd10);

        // start in the same cycle done is high
        do_start("dc1", FIPS_KEY);
        run_expand("dc1", 1'b0);
        start  = 1'b1;
        key_in = ZERO_KEY;
        step();
        start  = 1'b0;
        check_eq("dc_kv_drop", 128'(keys_valid), 128'd0);
        check_eq("dc_busy", 128'(busy), 128'd1);
        check_eq("dc_done_low", 128'(done), 128'd0);
        run_expand("dc2", 1'b0);
        step();
        exp_q.push_back(ZERO_RK1);  read_check("dc_rk1", 4'd1);
        exp_q.push_back(ZERO_RK10); read_check("dc_rk10", 4'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
